// File: rtl/epc_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// epc_pkg : shared types and helpers for the EPC register bridge
// Revision: 1.0
// ---------------------------------------------------------------------------
package epc_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        RD_WAIT = 3'd2,
        ACK     = 3'd3,
        HOLD    = 3'd4
    } epc_state_t;

    localparam logic [31:0] EPC_BAD_DATA = 32'hDEADBEEF;

    // EPC numbers byte enables MSB-first; the register bus numbers them LSB-first
    function automatic logic [3:0] be_swap(input logic [3:0] be);
        return {be[0], be[1], be[2], be[3]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/epc_reg_bridge.sv
`default_nettype none
// ---------------------------------------------------------------------------
// epc_reg_bridge : PS EPC slave decoding single-beat accesses onto a simple
//                  internal register bus (strobes + read acknowledge)
// Revision: 1.0
// ---------------------------------------------------------------------------
module epc_reg_bridge
    import epc_pkg::*;
#(
    parameter int          ADDR_WIDTH = 16,
    parameter int          TIMEOUT    = 8,
    parameter logic [31:0] BAD_DATA   = EPC_BAD_DATA
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           epc_addr,
    input  logic                  epc_ads,
    input  logic [3:0]            epc_be,
    input  logic                  epc_cs_n,
    input  logic                  epc_rnw,
    input  logic [31:0]           epc_data_o,
    output logic [31:0]           epc_data_i,
    output logic                  epc_rdy,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [31:0]           reg_wdata,
    output logic [3:0]            reg_be,
    output logic                  reg_wr,
    output logic                  reg_rd,
    input  logic [31:0]           reg_rdata,
    input  logic                  reg_rdack
);

    // TIMEOUT must stay below the PS abort limit of 10, so 4 bits always suffice
    localparam logic [3:0] C_TIMEOUT = 4'(TIMEOUT);

    epc_state_t            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  hit_q, hit_d;
    logic                  epc_rdy_q, epc_rdy_d;
    logic [31:0]           epc_data_i_q, epc_data_i_d;
    logic                  reg_wr_q, reg_wr_d;
    logic                  reg_rd_q, reg_rd_d;
    logic [ADDR_WIDTH-1:0] reg_addr_q, reg_addr_d;
    logic [31:0]           reg_wdata_q, reg_wdata_d;
    logic [3:0]            reg_be_q, reg_be_d;

    logic w_start;
    logic w_hit;
    logic w_unused_addr;

    assign w_start       = !epc_cs_n && epc_ads;
    assign w_hit         = (epc_addr[31:ADDR_WIDTH] == '0);
    assign w_unused_addr = ^epc_addr[1:0];

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hit_d        = hit_q;
        epc_data_i_d = epc_data_i_q;
        reg_addr_d   = reg_addr_q;
        reg_wdata_d  = reg_wdata_q;
        reg_be_d     = reg_be_q;
        epc_rdy_d    = 1'b0;
        reg_wr_d     = 1'b0;
        reg_rd_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (w_start) begin
                    reg_addr_d  = {epc_addr[ADDR_WIDTH-1:2], 2'b00};
                    reg_wdata_d = epc_data_o;
                    reg_be_d    = be_swap(epc_be);
                    hit_d       = w_hit;
                    cnt_d       = 4'd0;
                    if (epc_rnw) begin
                        state_d  = RD_WAIT;
                        reg_rd_d = w_hit;
                    end else begin
                        state_d  = WR;
                        reg_wr_d = w_hit && (epc_be != 4'b0000);
                    end
                end
            end
            WR: begin
                if (epc_cs_n) begin
                    state_d = IDLE;
                end else begin
                    state_d   = ACK;
                    epc_rdy_d = 1'b1;
                end
            end
            RD_WAIT: begin
                // An abort wins over a same-cycle acknowledge; no data is returned
                if (epc_cs_n) begin
                    state_d = IDLE;
                end else if (!hit_q) begin
                    epc_data_i_d = BAD_DATA;
                    state_d      = ACK;
                    epc_rdy_d    = 1'b1;
                end else if (reg_rdack) begin
                    epc_data_i_d = reg_rdata;
                    state_d      = ACK;
                    epc_rdy_d    = 1'b1;
                end else if (cnt_q == C_TIMEOUT) begin
                    epc_data_i_d = BAD_DATA;
                    state_d      = ACK;
                    epc_rdy_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ACK: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (epc_cs_n) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            hit_q        <= 1'b0;
            epc_rdy_q    <= 1'b0;
            epc_data_i_q <= 32'd0;
            reg_wr_q     <= 1'b0;
            reg_rd_q     <= 1'b0;
            reg_addr_q   <= '0;
            reg_wdata_q  <= 32'd0;
            reg_be_q     <= 4'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hit_q        <= hit_d;
            epc_rdy_q    <= epc_rdy_d;
            epc_data_i_q <= epc_data_i_d;
            reg_wr_q     <= reg_wr_d;
            reg_rd_q     <= reg_rd_d;
            reg_addr_q   <= reg_addr_d;
            reg_wdata_q  <= reg_wdata_d;
            reg_be_q     <= reg_be_d;
        end
    end

    assign epc_rdy    = epc_rdy_q;
    assign epc_data_i = epc_data_i_q;
    assign reg_wr     = reg_wr_q;
    assign reg_rd     = reg_rd_q;
    assign reg_addr   = reg_addr_q;
    assign reg_wdata  = reg_wdata_q;
    assign reg_be     = reg_be_q;

endmodule
`default_nettype wire

// File: tb/tb_epc_reg_bridge.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_epc_reg_bridge : directed bench for epc_reg_bridge with a timing model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_epc_reg_bridge;

    localparam int          AW      = 16;
    localparam int          TMO     = 8;
    localparam logic [31:0] BAD     = 32'hDEADBEEF;
    localparam logic [31:0] JUNK    = 32'h11111111;
    localparam int          NO_ACK  = 99;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   epc_addr;
    logic          epc_ads;
    logic [3:0]    epc_be;
    logic          epc_cs_n;
    logic          epc_rnw;
    logic [31:0]   epc_data_o;
    logic [31:0]   epc_data_i;
    logic          epc_rdy;
    logic [AW-1:0] reg_addr;
    logic [31:0]   reg_wdata;
    logic [3:0]    reg_be;
    logic          reg_wr;
    logic          reg_rd;
    logic [31:0]   reg_rdata;
    logic          reg_rdack;

    epc_reg_bridge #(.ADDR_WIDTH(AW), .TIMEOUT(TMO), .BAD_DATA(BAD)) dut (
        .clk(clk), .rst_n(rst_n),
        .epc_addr(epc_addr), .epc_ads(epc_ads), .epc_be(epc_be),
        .epc_cs_n(epc_cs_n), .epc_rnw(epc_rnw), .epc_data_o(epc_data_o),
        .epc_data_i(epc_data_i), .epc_rdy(epc_rdy),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_be(reg_be),
        .reg_wr(reg_wr), .reg_rd(reg_rd),
        .reg_rdata(reg_rdata), .reg_rdack(reg_rdack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: strobe/ready cycles plus held values (0 addr, 1 wdata, 2 be, 3 data_i)
    int          exp_wr  = -1;
    int          exp_rd  = -1;
    int          exp_rdy = -1;
    logic [31:0] h_old [4] = '{default: 32'd0};
    logic [31:0] h_new [4] = '{default: 32'd0};
    int          h_chg [4] = '{default: 0};

    int last_wr  = -1;
    int last_rd  = -1;
    int last_rdy = -1;
    int n_rdy    = 0;

    function automatic logic [31:0] hv(input int i);
        return (cyc >= h_chg[i]) ? h_new[i] : h_old[i];
    endfunction

    task automatic set_h(input int i, input logic [31:0] v, input int c);
        h_old[i] = hv(i);
        h_new[i] = v;
        h_chg[i] = c;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (cyc >= 1) begin
            chk("reg_wr",     {31'd0, reg_wr},  {31'd0, cyc == exp_wr});
            chk("reg_rd",     {31'd0, reg_rd},  {31'd0, cyc == exp_rd});
            chk("epc_rdy",    {31'd0, epc_rdy}, {31'd0, cyc == exp_rdy});
            chk("reg_addr",   {16'd0, reg_addr}, hv(0));
            chk("reg_wdata",  reg_wdata, hv(1));
            chk("reg_be",     {28'd0, reg_be}, hv(2));
            chk("epc_data_i", epc_data_i, hv(3));
            if (reg_wr === 1'b1) last_wr = cyc;
            if (reg_rd === 1'b1) last_rd = cyc;
            if (epc_rdy === 1'b1) begin
                last_rdy = cyc;
                n_rdy++;
            end
        end
    end

    // One EPC access. ack_d: cycles after the reg_rd cycle that reg_rdack comes.
    // intr_at >= 0 interrupts that many cycles after the start edge, either by
    // raising cs_n (abort) or by pulling rst_n low.
    task automatic txn(input logic [31:0] addr, input logic rnw, input logic [3:0] be,
                       input logic [31:0] wd, input int ack_d, input logic [31:0] rdata,
                       input int intr_at, input bit intr_rst);
        int          n;
        bit          hit;
        bit          abort;
        logic [3:0]  sbe;
        logic [31:0] rd_val;
        int          fin;
        n     = cyc + 1;
        hit   = ((addr >> AW) == 0);
        abort = (intr_at >= 0) && !intr_rst;
        for (int i = 0; i < 4; i++) sbe[3-i] = be[i];
        epc_addr = addr; epc_rnw = rnw; epc_be = be; epc_data_o = wd;
        epc_cs_n = 1'b0; epc_ads = 1'b1;

        set_h(0, {16'd0, addr[15:2], 2'b00}, n);
        set_h(1, wd, n);
        set_h(2, {28'd0, sbe}, n);
        exp_wr = -1;
        exp_rd = -1;
        rd_val = BAD;
        if (!rnw) begin
            if (hit && be != 4'd0) exp_wr = n;
            exp_rdy = n + 1;
        end else if (!hit) begin
            exp_rdy = n + 1;
        end else begin
            exp_rd = n;
            if (ack_d <= TMO) begin
                exp_rdy = n + ack_d + 1;
                rd_val  = rdata;
            end else begin
                exp_rdy = n + TMO + 1;
            end
        end
        if (abort) exp_rdy = -1;
        if (rnw && exp_rdy >= 0 && !(intr_rst && intr_at < exp_rdy - n)) set_h(3, rd_val, exp_rdy);

        step(1);
        epc_ads = 1'b0;
        if (intr_at >= 0) begin
            step(intr_at);
            if (intr_rst) begin
                rst_n = 1'b0;
                for (int i = 0; i < 4; i++) set_h(i, 32'd0, cyc + 1);
                exp_rdy = -1;
                if (exp_wr > cyc) exp_wr = -1;
                if (exp_rd > cyc) exp_rd = -1;
                step(1);
                rst_n = 1'b1;
            end
            epc_cs_n = 1'b1;
            step(2);
        end else begin
            if (rnw && hit && ack_d <= TMO) begin
                step(ack_d);
                reg_rdack = 1'b1; reg_rdata = rdata;
                step(1);
                reg_rdack = 1'b0; reg_rdata = JUNK;
            end
            fin = exp_rdy + 1;
            while (cyc < fin) step(1);
            epc_cs_n = 1'b1;
            step(2);
        end
    endtask

    int saved_rdy;

    initial begin
        rst_n = 1'b0; epc_addr = 32'd0; epc_ads = 1'b0; epc_be = 4'd0;
        epc_cs_n = 1'b1; epc_rnw = 1'b0; epc_data_o = 32'd0;
        reg_rdata = JUNK; reg_rdack = 1'b0;
        step(3);
        chk("rst_epc_rdy", {31'd0, epc_rdy}, 32'd0);
        chk("rst_data_i",  epc_data_i, 32'd0);
        chk("rst_reg_be",  {28'd0, reg_be}, 32'd0);
        rst_n = 1'b1;
        step(2);

        txn(32'h0000_0100, 1'b0, 4'hF, 32'h1234_5678, 0, 0, -1, 1'b0);
        chk("wr1_addr",  {16'd0, reg_addr}, 32'h0000_0100);
        chk("wr1_wdata", reg_wdata, 32'h1234_5678);
        chk("wr1_lat",   last_rdy - last_wr, 1);

        txn(32'hAAAA_AAAA, 1'b0, 4'hF, 32'h5555_5555, 0, 0, -1, 1'b0);
        txn(32'hA5A5_A5A5, 1'b1, 4'hF, 32'h0, 0, 0, -1, 1'b0);
        chk("rdmiss_data", epc_data_i, 32'hDEAD_BEEF);

        // Stray acknowledge while idle must be ignored
        reg_rdack = 1'b1; reg_rdata = 32'h9999_9999;
        step(1);
        reg_rdack = 1'b0; reg_rdata = JUNK;
        step(1);

        txn(32'h0000_0314, 1'b1, 4'hF, 32'h0, 3, 32'hCAFE_0001, -1, 1'b0);
        chk("rd_ack3_data", epc_data_i, 32'hCAFE_0001);
        chk("rd_ack3_lat",  last_rdy - last_rd, 4);

        txn(32'h0000_0100, 1'b1, 4'hF, 32'h0, NO_ACK, 0, -1, 1'b0);
        chk("rd_tmo_data", epc_data_i, 32'hDEAD_BEEF);
        chk("rd_tmo_lat",  last_rdy - last_rd, TMO + 1);

        txn(32'h0000_0104, 1'b0, 4'b0001, 32'h0BAD_F00D, 0, 0, -1, 1'b0);
        chk("be_swap", {28'd0, reg_be}, 32'h8);

        txn(32'h0000_0108, 1'b0, 4'h0, 32'h0000_0042, 0, 0, -1, 1'b0);
        txn(32'h0000_0010, 1'b1, 4'hF, 32'h0, 0, 32'h0000_ABCD, -1, 1'b0);
        txn(32'h0000_0020, 1'b1, 4'hF, 32'h0, TMO, 32'h0000_1357, -1, 1'b0);
        chk("rd_ack_tmo_edge", epc_data_i, 32'h0000_1357);

        txn(32'h0000_0300, 1'b0, 4'hF, 32'h7777_0000, 0, 0, 0, 1'b0);

        saved_rdy = n_rdy;
        txn(32'h0000_0200, 1'b1, 4'hF, 32'h0, NO_ACK, 0, 3, 1'b1);
        chk("rst_rd_data", epc_data_i, 32'd0);
        chk("rst_rd_nordy", n_rdy - saved_rdy, 0);

        txn(32'h0000_0200, 1'b0, 4'hF, 32'h0000_0080, 0, 0, -1, 1'b0);
        chk("post_rst_wdata", reg_wdata, 32'h0000_0080);
        chk("post_rst_lat",   last_rdy - last_wr, 1);

        step(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
